// File: rtl/loop_sched_pkg.sv
// Shared types and default widths for the modulo-scheduled loop controller.
// Nothing here depends on LOOP_SCHED_STALL_EN.
package loop_sched_pkg;

    localparam int LCWIDTH  = 16;
    localparam int IIWIDTH  = 8;
    localparam int ESCWIDTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        KERNEL   = 2'd1,
        EPILOGUE = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/loop_sched_if.sv
// Control and brf-side signal bundle for loop_sched, plus the FSM state for observation.
// LOOP_SCHED_STALL_EN adds the stall input.
interface loop_sched_if import loop_sched_pkg::*; #(
    parameter int LCWIDTH  = loop_sched_pkg::LCWIDTH,
    parameter int IIWIDTH  = loop_sched_pkg::IIWIDTH,
    parameter int ESCWIDTH = loop_sched_pkg::ESCWIDTH
) ();
    // start is a level sampled only in IDLE (no queuing); done is a one-cycle pulse.
    // brf_p, brf_lc_out and brf_lc_enable are only looked at on a cycle where brf_enable is high.
    logic                start;
    logic [LCWIDTH-1:0]  trip_count;
    logic [IIWIDTH-1:0]  ii;
    logic [ESCWIDTH-1:0] esc;
    logic                busy;
    logic                done;
    logic                iter_start;
    logic                brf_op;
    logic                brf_enable;
    logic                brf_running;
    logic [LCWIDTH-1:0]  brf_lc;
    logic                brf_p;
    logic [LCWIDTH-1:0]  brf_lc_out;
    logic                brf_lc_enable;
    state_t              state;
`ifdef LOOP_SCHED_STALL_EN
    logic                stall;
`endif

    modport master (
        output start, trip_count, ii, esc, brf_p, brf_lc_out, brf_lc_enable,
`ifdef LOOP_SCHED_STALL_EN
        output stall,
`endif
        input  busy, done, iter_start, brf_op, brf_enable, brf_running, brf_lc, state
    );

    modport slave (
        input  start, trip_count, ii, esc, brf_p, brf_lc_out, brf_lc_enable,
`ifdef LOOP_SCHED_STALL_EN
        input  stall,
`endif
        output busy, done, iter_start, brf_op, brf_enable, brf_running, brf_lc, state
    );

endinterface

// File: rtl/loop_sched_ii_cnt.sv
// Wrapping initiation-interval window counter: counts 0..ii_reg-1, flags first and last cycle.
// clear forces zero, hold freezes the count.
module loop_sched_ii_cnt import loop_sched_pkg::*; #(
    parameter int IIWIDTH = loop_sched_pkg::IIWIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               hold,
    input  logic [IIWIDTH-1:0] ii_reg,
    output logic               first,
    output logic               last
);
    logic [IIWIDTH-1:0] cnt;

    assign first = (cnt == '0);
    assign last  = (cnt == ii_reg - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/loop_sched.sv
// Modulo-scheduled loop controller driving one brf macrocell: kernel, epilogue drain, done pulse.
// Optional LOOP_SCHED_STALL_EN adds a stall input that freezes the active window.
module loop_sched import loop_sched_pkg::*; #(
    parameter int LCWIDTH  = loop_sched_pkg::LCWIDTH,
    parameter int IIWIDTH  = loop_sched_pkg::IIWIDTH,
    parameter int ESCWIDTH = loop_sched_pkg::ESCWIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    loop_sched_if.slave bus
);
    state_t              state, state_nxt;
    logic [IIWIDTH-1:0]  ii_reg, ii_reg_nxt;
    logic [ESCWIDTH-1:0] esc_cnt, esc_cnt_nxt;
    logic [LCWIDTH-1:0]  brf_lc, brf_lc_nxt;
    logic                active;
    logic                stall_act;
    logic                win_first;
    logic                win_last;
    logic                op;

    assign active = (state == KERNEL) || (state == EPILOGUE);

`ifdef LOOP_SCHED_STALL_EN
    assign stall_act = active && bus.stall;
`else
    assign stall_act = 1'b0;
`endif

    // The counter sits at zero outside the loop, so KERNEL always opens on window cycle 0.
    loop_sched_ii_cnt #(.IIWIDTH(IIWIDTH)) u_ii_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!active),
        .hold    (stall_act),
        .ii_reg  (ii_reg),
        .first   (win_first),
        .last    (win_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            ii_reg  <= IIWIDTH'(1);
            esc_cnt <= '0;
            brf_lc  <= '0;
        end else begin
            state   <= state_nxt;
            ii_reg  <= ii_reg_nxt;
            esc_cnt <= esc_cnt_nxt;
            brf_lc  <= brf_lc_nxt;
        end
    end

    assign op = (state == KERNEL) && win_last && !stall_act;

    always_comb begin
        state_nxt       = state;
        ii_reg_nxt      = ii_reg;
        esc_cnt_nxt     = esc_cnt;
        brf_lc_nxt      = brf_lc;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.iter_start  = 1'b0;
        bus.brf_op      = 1'b0;
        bus.brf_enable  = 1'b0;
        bus.brf_running = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.trip_count == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = KERNEL;
                        ii_reg_nxt  = (bus.ii == '0) ? IIWIDTH'(1) : bus.ii;
                        brf_lc_nxt  = bus.trip_count - 1'b1;
                        esc_cnt_nxt = bus.esc;
                    end
                end
            end
            KERNEL: begin
                bus.busy        = 1'b1;
                bus.brf_running = 1'b1;
                bus.iter_start  = win_first && !stall_act;
                bus.brf_op      = op;
                bus.brf_enable  = op;
                if (op) begin
                    if (bus.brf_lc_enable) brf_lc_nxt = bus.brf_lc_out;
                    if (!bus.brf_p) state_nxt = (esc_cnt == '0) ? DONE : EPILOGUE;
                end
            end
            EPILOGUE: begin
                bus.busy       = 1'b1;
                bus.iter_start = win_first && !stall_act;
                if (win_last && !stall_act) begin
                    if (esc_cnt == ESCWIDTH'(1)) state_nxt = DONE;
                    else esc_cnt_nxt = esc_cnt - 1'b1;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.brf_lc = brf_lc;
    assign bus.state  = state;

endmodule

// File: tb/tb_loop_sched.sv
// Scoreboard bench for loop_sched with a behavioural brf attached and a window-level reference model.
// Exercises LOOP_SCHED_STALL_EN stalls when the macro is defined.
module tb_loop_sched;
    import loop_sched_pkg::*;

    localparam int VW = 2 + 6 + LCWIDTH;
`ifdef LOOP_SCHED_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    loop_sched_if bus ();

    loop_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // behavioural brf: continue while the count is non-zero, decrement on each op
    assign bus.brf_p         = (bus.brf_lc != '0);
    assign bus.brf_lc_out    = bus.brf_lc - 1'b1;
    assign bus.brf_lc_enable = bus.brf_enable && (bus.brf_lc != '0);

    // scoreboard state
    logic [VW-1:0]      exp_q[$];
    logic [LCWIDTH-1:0] model_lc = '0;
    int                 errors = 0;
    int                 checks = 0;
    int                 cyc = 0;
    bit                 mon_en = 1'b0;
    logic [VW-1:0]      act_v;
    logic [VW-1:0]      exp_v;

    function automatic logic [VW-1:0] vec(state_t s, bit busy, bit done, bit it, bit op,
                                          bit run, logic [LCWIDTH-1:0] lc);
        return {s, busy, done, it, op, op, run, lc};
    endfunction

    function automatic bit pick_stall(int smode, int t);
        if (!STALL_EN) return 1'b0;
        if (smode == 1) return ($urandom_range(0, 3) == 0);
        if (smode == 2) return (t >= 2 && t <= 4);
        return 1'b0;
    endfunction

    task automatic drive_stall(input bit s);
`ifdef LOOP_SCHED_STALL_EN
        bus.stall = s;
`else
        if (s) $display("note: stall requested without stall support");
`endif
    endtask

    // monitor: one comparison per cycle; empty queue means the block must sit idle
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            act_v = {bus.state, bus.busy, bus.done, bus.iter_start, bus.brf_op,
                     bus.brf_enable, bus.brf_running, bus.brf_lc};
            if (exp_q.size() != 0) exp_v = exp_q.pop_front();
            else exp_v = vec(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_lc);
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_vec cyc=%0d actual{st,busy,done,it,op,en,run,lc}=%h expected=%h",
                         cyc, act_v, exp_v);
            end
        end
    end

    // Model works per II window: window w < n is a kernel iteration, the rest drain the epilogue.
    // reset_at >= 0 asserts reset in that job cycle and abandons the loop.
    task automatic run_job(input int n, input int ii_in, input int esc_in, input int smode,
                           input int reset_at);
        int iie, total, w, p, ncyc;
        bit s, kern;
        bit stl[$];
        logic [LCWIDTH-1:0] lc;
        logic [VW-1:0] dropped;
        iie   = (ii_in == 0) ? 1 : ii_in;
        total = n + esc_in;
        w = 0;
        p = 0;
        stl.push_back(pick_stall(smode, 0));
        exp_q.push_back(vec(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_lc));
        if (n > 0) begin
            while (w < total) begin
                s = pick_stall(smode, stl.size());
                stl.push_back(s);
                kern = (w < n);
                lc = kern ? LCWIDTH'(n - 1 - w) : '0;
                if (s) begin
                    exp_q.push_back(vec(kern ? KERNEL : EPILOGUE, 1'b1, 1'b0, 1'b0, 1'b0, kern, lc));
                end else begin
                    exp_q.push_back(vec(kern ? KERNEL : EPILOGUE, 1'b1, 1'b0, (p == 0),
                                        kern && (p == iie - 1), kern, lc));
                    p++;
                    if (p == iie) begin
                        p = 0;
                        w++;
                    end
                end
            end
            model_lc = '0;
        end
        stl.push_back(pick_stall(smode, stl.size()));
        exp_q.push_back(vec(DONE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_lc));
        ncyc = stl.size();
        if (reset_at >= 0) begin
            ncyc = reset_at + 1;
            while (exp_q.size() > ncyc) dropped = exp_q.pop_back();
        end

        // driver: cycle 0 carries the real request, later cycles carry ignored garbage starts
        bus.start      = 1'b1;
        bus.trip_count = LCWIDTH'(n);
        bus.ii         = IIWIDTH'(ii_in);
        bus.esc        = ESCWIDTH'(esc_in);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) begin
                bus.start      = ($urandom_range(0, 3) == 0);
                bus.trip_count = LCWIDTH'($urandom_range(0, 9));
                bus.ii         = IIWIDTH'($urandom_range(0, 5));
                bus.esc        = ESCWIDTH'($urandom_range(0, 3));
            end
            drive_stall(stl[i]);
            if (i == reset_at) reset_n = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        drive_stall(1'b0);
        if (reset_at >= 0) begin
            reset_n  = 1'b1;
            model_lc = '0;
        end

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.trip_count = '0;
        bus.ii         = '0;
        bus.esc        = '0;
        drive_stall(1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en  = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(3, 2, 1, 0, -1);
        run_job(0, 3, 2, 0, -1);
        run_job(4, 1, 0, 0, -1);
        run_job(4, 0, 0, 0, -1);
        run_job(2, 2, 3, 0, 6);
        run_job(1, 3, 1, 0, -1);
        run_job(2, 3, 0, 2, -1);
        for (int j = 0; j < 40; j++) begin
            run_job($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), 1, -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog cyc=%0d limit=200000", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
